// File: rtl/pipe_hazard_pkg.sv
// rtl/pipe_hazard_pkg.sv - shared types, encodings and helpers for the pipeline hazard unit
//   FWD_*        : EX operand-select encodings
//   SB_AW        : register-address width held in scoreboard entries (REG_AW must not exceed it)
//   *_entry_t    : scoreboard entries for the EX, MEM and WB stages
//   sat_inc()    : saturating increment of a W-bit value carried in 64 bits
package pipe_hazard_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Register numbers are zero-extended into this width, so one set of
  // entry types serves every REG_AW up to SB_AW.
  localparam int SB_AW = 8;

  typedef struct packed {
    logic             v;
    logic [SB_AW-1:0] rs;
    logic [SB_AW-1:0] rt;
    logic             rs_used;
    logic             rt_used;
    logic [SB_AW-1:0] rd;
    logic             regw;
    logic             load;
    logic             mem;
  } ex_entry_t;

  typedef struct packed {
    logic             v;
    logic [SB_AW-1:0] rd;
    logic             regw;
    logic             load;
    logic             mem;
  } mem_entry_t;

  typedef struct packed {
    logic             v;
    logic [SB_AW-1:0] rd;
    logic             regw;
  } wb_entry_t;

  // Holds at all-ones for a w-bit counter; w must be below 64.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned w);
    logic [63:0] max_v;
    max_v = (64'd1 << w) - 64'd1;
    return (val == max_v) ? val : val + 64'd1;
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_sat_counter.sv
// rtl/pipe_hazard_unit_sat_counter.sv - W-bit saturating event counter
//   clk   : clock
//   rst   : asynchronous active-low reset, clears count
//   inc   : count one event this cycle
//   count : current value, sticks at all-ones
module sat_counter
  import pipe_hazard_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [63:0] nxt;
  logic [63:W] nxt_hi_unused;

  assign nxt           = sat_inc({{(64-W){1'b0}}, count}, W);
  // Upper bits are always zero because count never exceeds W bits.
  assign nxt_hi_unused = nxt[63:W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc) begin
      count <= nxt[W-1:0];
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - stall/flush/forwarding controller for a 5-stage MIPS pipeline
//   clk, rst                  : clock, asynchronous active-low reset
//   id_valid .. id_mem        : decoded fields of the instruction in ID
//   br_taken                  : EX resolved a taken branch/jump this cycle
//   dm_ready                  : data memory finishes the MEM access this cycle
//   pc_wr .. mem_wb_wr        : pipeline-register write enables
//   if_id_flush, id_ex_flush  : load a bubble into IF/ID, ID/EX
//   fwd_a, fwd_b              : EX operand selects (FWD_* encodings)
//   stall_cnt, flush_cnt      : saturating counts of stalled cycles and taken redirects
module pipe_hazard_unit
  import pipe_hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regw,
  input  logic              id_load,
  input  logic              id_mem,
  input  logic              br_taken,
  input  logic              dm_ready,
  output logic              pc_wr,
  output logic              if_id_wr,
  output logic              id_ex_wr,
  output logic              ex_mem_wr,
  output logic              mem_wb_wr,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  ex_entry_t  ex_q;
  mem_entry_t mem_q;
  wb_entry_t  wb_q;
  logic       br_pend_q;

  logic [SB_AW-1:0] rs_x, rt_x, rd_x;
  assign rs_x = SB_AW'(id_rs);
  assign rt_x = SB_AW'(id_rt);
  assign rd_x = SB_AW'(id_rd);

  // A read of src depends on a producer writing rd; register 0 never does.
  function automatic logic src_hit(input logic [SB_AW-1:0] src, input logic used,
                                   input logic v, input logic regw,
                                   input logic [SB_AW-1:0] rd);
    return used && v && regw && (rd == src) && (src != '0);
  endfunction

  // ---------------- forwarding selects ----------------
  logic [1:0] fwd_a_c, fwd_b_c;

  always_comb begin
    fwd_a_c = FWD_RF;
    fwd_b_c = FWD_RF;
    if (FWD_EN != 0) begin
      // MEM holds the younger producer, so it wins over WB.
      if (src_hit(ex_q.rs, ex_q.v & ex_q.rs_used, mem_q.v, mem_q.regw, mem_q.rd))
        fwd_a_c = FWD_EXMEM;
      else if (src_hit(ex_q.rs, ex_q.v & ex_q.rs_used, wb_q.v, wb_q.regw, wb_q.rd))
        fwd_a_c = FWD_MEMWB;
      if (src_hit(ex_q.rt, ex_q.v & ex_q.rt_used, mem_q.v, mem_q.regw, mem_q.rd))
        fwd_b_c = FWD_EXMEM;
      else if (src_hit(ex_q.rt, ex_q.v & ex_q.rt_used, wb_q.v, wb_q.regw, wb_q.rd))
        fwd_b_c = FWD_MEMWB;
    end
  end

  // ---------------- hazard detection ----------------
  logic ex_hit, mem_hit, wb_hit;
  logic raw_ld, raw_any, raw;
  logic mem_wait, redirect, stall;

  assign ex_hit  = src_hit(rs_x, id_rs_used, ex_q.v, ex_q.regw, ex_q.rd)
                 | src_hit(rt_x, id_rt_used, ex_q.v, ex_q.regw, ex_q.rd);
  assign mem_hit = src_hit(rs_x, id_rs_used, mem_q.v, mem_q.regw, mem_q.rd)
                 | src_hit(rt_x, id_rt_used, mem_q.v, mem_q.regw, mem_q.rd);
  assign wb_hit  = src_hit(rs_x, id_rs_used, wb_q.v, wb_q.regw, wb_q.rd)
                 | src_hit(rt_x, id_rt_used, wb_q.v, wb_q.regw, wb_q.rd);

  // With forwarding only a load in EX is too late; without it the reader
  // waits until the producer has left WB.
  assign raw_ld  = id_valid & ex_q.load & ex_hit;
  assign raw_any = id_valid & (ex_hit | mem_hit | wb_hit);
  assign raw     = (FWD_EN != 0) ? raw_ld : raw_any;

  assign mem_wait = mem_q.v & mem_q.mem & ~dm_ready;
  // A redirect squashes the ID instruction, so its hazard no longer matters.
  assign redirect = ~mem_wait & (br_taken | br_pend_q);
  assign stall    = ~mem_wait & ~redirect & raw;

  logic pc_wr_c, id_ex_flush_c;
  assign pc_wr_c       = ~mem_wait & ~stall;
  assign id_ex_flush_c = redirect | stall;

  // Outputs fall back to their reset values while rst is held low,
  // independent of any pending input such as br_taken.
  assign pc_wr       = ~rst | pc_wr_c;
  assign if_id_wr    = ~rst | pc_wr_c;
  assign id_ex_wr    = ~rst | ~mem_wait;
  assign ex_mem_wr   = ~rst | ~mem_wait;
  assign mem_wb_wr   = ~rst | ~mem_wait;
  assign if_id_flush = rst & redirect;
  assign id_ex_flush = rst & id_ex_flush_c;
  assign fwd_a       = rst ? fwd_a_c : FWD_RF;
  assign fwd_b       = rst ? fwd_b_c : FWD_RF;

  // ---------------- scoreboard ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      br_pend_q <= 1'b0;
    end else if (mem_wait) begin
      // Pipeline frozen: remember a redirect that EX could not act on.
      br_pend_q <= br_pend_q | br_taken;
    end else begin
      br_pend_q  <= 1'b0;
      wb_q.v     <= mem_q.v;
      wb_q.rd    <= mem_q.rd;
      wb_q.regw  <= mem_q.regw;
      mem_q.v    <= ex_q.v;
      mem_q.rd   <= ex_q.rd;
      mem_q.regw <= ex_q.regw;
      mem_q.load <= ex_q.load;
      mem_q.mem  <= ex_q.mem;
      if (id_ex_flush_c || !id_valid) begin
        ex_q <= '0;
      end else begin
        ex_q.v       <= 1'b1;
        ex_q.rs      <= rs_x;
        ex_q.rt      <= rt_x;
        ex_q.rs_used <= id_rs_used;
        ex_q.rt_used <= id_rt_used;
        ex_q.rd      <= rd_x;
        ex_q.regw    <= id_regw;
        ex_q.load    <= id_load;
        ex_q.mem     <= id_mem;
      end
    end
  end

  // ---------------- performance counters ----------------
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~pc_wr_c),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (redirect),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb/tb_pipe_hazard_unit.sv - scoreboard bench for pipe_hazard_unit (forwarding and non-forwarding builds)
module tb_pipe_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs_used, id_rt_used, id_regw, id_load, id_mem;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       br_taken, dm_ready;

  logic        pc_wr1, if_id_wr1, id_ex_wr1, ex_mem_wr1, mem_wb_wr1, if_id_flush1, id_ex_flush1;
  logic [1:0]  fwd_a1, fwd_b1;
  logic [15:0] stall_cnt1, flush_cnt1;
  logic        pc_wr0, if_id_wr0, id_ex_wr0, ex_mem_wr0, mem_wb_wr0, if_id_flush0, id_ex_flush0;
  logic [1:0]  fwd_a0, fwd_b0;
  logic [15:0] stall_cnt0, flush_cnt0;

  always #5 clk = ~clk;

  pipe_hazard_unit #(.REG_AW(5), .FWD_EN(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_regw(id_regw),
    .id_load(id_load), .id_mem(id_mem), .br_taken(br_taken), .dm_ready(dm_ready),
    .pc_wr(pc_wr1), .if_id_wr(if_id_wr1), .id_ex_wr(id_ex_wr1), .ex_mem_wr(ex_mem_wr1),
    .mem_wb_wr(mem_wb_wr1), .if_id_flush(if_id_flush1), .id_ex_flush(id_ex_flush1),
    .fwd_a(fwd_a1), .fwd_b(fwd_b1), .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
  );

  pipe_hazard_unit #(.REG_AW(5), .FWD_EN(0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_regw(id_regw),
    .id_load(id_load), .id_mem(id_mem), .br_taken(br_taken), .dm_ready(dm_ready),
    .pc_wr(pc_wr0), .if_id_wr(if_id_wr0), .id_ex_wr(id_ex_wr0), .ex_mem_wr(ex_mem_wr0),
    .mem_wb_wr(mem_wb_wr0), .if_id_flush(if_id_flush0), .id_ex_flush(id_ex_flush0),
    .fwd_a(fwd_a0), .fwd_b(fwd_b0), .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
  );

  // {pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr, if_id_flush, id_ex_flush}
  localparam logic [6:0] WE  = 7'b1111100;
  localparam logic [6:0] STL = 7'b0011101;
  localparam logic [6:0] FRZ = 7'b0000000;
  localparam logic [6:0] RDR = 7'b1111111;

  typedef struct {
    string       nm;
    int          sel;   // 1: forwarding DUT, 0: non-forwarding DUT, 2: no check
    logic [42:0] exp;
  } chk_t;

  chk_t        sbq[$];
  chk_t        mon_e;
  logic [42:0] act1, act0, mon_act;
  int          total = 0;
  int          bad   = 0;

  assign act1 = {pc_wr1, if_id_wr1, id_ex_wr1, ex_mem_wr1, mem_wb_wr1, if_id_flush1, id_ex_flush1,
                 fwd_a1, fwd_b1, stall_cnt1, flush_cnt1};
  assign act0 = {pc_wr0, if_id_wr0, id_ex_wr0, ex_mem_wr0, mem_wb_wr0, if_id_flush0, id_ex_flush0,
                 fwd_a0, fwd_b0, stall_cnt0, flush_cnt0};

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      if (mon_e.sel != 2) begin
        mon_act = (mon_e.sel == 1) ? act1 : act0;
        total++;
        if (mon_act !== mon_e.exp) begin
          bad++;
          $display("FAIL %s: got ctl=%b fa=%b fb=%b sc=%0d fc=%0d, want ctl=%b fa=%b fb=%b sc=%0d fc=%0d",
                   mon_e.nm, mon_act[42:36], mon_act[35:34], mon_act[33:32], mon_act[31:16], mon_act[15:0],
                   mon_e.exp[42:36], mon_e.exp[35:34], mon_e.exp[33:32], mon_e.exp[31:16], mon_e.exp[15:0]);
        end
      end
    end
  end

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic rsu, input logic rtu, input logic [4:0] rd,
                        input logic regw, input logic ld, input logic mem);
    id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
    id_rd = rd; id_regw = regw; id_load = ld; id_mem = mem;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Push this cycle's expectation, then move to just after the next edge.
  task automatic tick(input string nm, input int sel, input logic [6:0] wf,
                      input logic [1:0] fa, input logic [1:0] fb, input int sc, input int fc);
    chk_t e;
    logic [15:0] sc16, fc16;
    sc16 = sc[15:0];
    fc16 = fc[15:0];
    e.nm  = nm;
    e.sel = sel;
    e.exp = {wf, fa, fb, sc16, fc16};
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    nop(); br_taken = 0; dm_ready = 1;
    rst = 0;
    tick("skip", 2, WE, 0, 0, 0, 0);
    rst = 1;
  endtask

  initial begin
    rst = 0; br_taken = 0; dm_ready = 1;
    nop();
    @(posedge clk); #1;
    tick("reset_fwd",   1, WE, 2'b00, 2'b00, 0, 0);
    tick("reset_nofwd", 0, WE, 2'b00, 2'b00, 0, 0);
    rst = 1;

    // Test 1: EX/MEM and MEM/WB forwarding, MEM priority.
    set_id(1, 1, 2, 1, 1, 3, 1, 0, 0); tick("t1_add",      1, WE, 2'b00, 2'b00, 0, 0);
    set_id(1, 6, 7, 1, 1, 3, 1, 0, 0); tick("t1_and",      1, WE, 2'b00, 2'b00, 0, 0);
    set_id(1, 3, 5, 1, 1, 8, 1, 0, 0); tick("t1_or",       1, WE, 2'b00, 2'b00, 0, 0);
    set_id(1, 5, 3, 1, 1, 4, 1, 0, 0); tick("t1_mem_prio", 1, WE, 2'b01, 2'b00, 0, 0);
    nop();                             tick("t1_wb_fwd",   1, WE, 2'b00, 2'b10, 0, 0);
    nop();                             tick("t1_clear",    1, WE, 2'b00, 2'b00, 0, 0);

    // Test 2: load-use, forwarding build.
    rst_pulse();
    set_id(1, 0, 3, 1, 0, 3, 1, 1, 1); tick("t2_lw",      1, WE,  2'b00, 2'b00, 0, 0);
    set_id(1, 3, 3, 1, 1, 4, 1, 0, 0); tick("t2_stall",   1, STL, 2'b00, 2'b00, 0, 0);
    tick("t2_resume", 1, WE, 2'b00, 2'b00, 1, 0);
    nop();                             tick("t2_fwd_wb",  1, WE,  2'b10, 2'b10, 1, 0);

    // Test 3: same sequence, non-forwarding build.
    rst_pulse();
    set_id(1, 0, 3, 1, 0, 3, 1, 1, 1); tick("t3_lw",     0, WE,  2'b00, 2'b00, 0, 0);
    set_id(1, 3, 3, 1, 1, 4, 1, 0, 0); tick("t3_stall1", 0, STL, 2'b00, 2'b00, 0, 0);
    tick("t3_stall2", 0, STL, 2'b00, 2'b00, 1, 0);
    tick("t3_stall3", 0, STL, 2'b00, 2'b00, 2, 0);
    tick("t3_resume", 0, WE,  2'b00, 2'b00, 3, 0);
    nop();                             tick("t3_no_fwd", 0, WE,  2'b00, 2'b00, 3, 0);

    // Test 4: taken branch in the same cycle as a load-use hazard.
    rst_pulse();
    set_id(1, 0, 3, 1, 0, 3, 1, 1, 1); tick("t4_lw",    1, WE,  2'b00, 2'b00, 0, 0);
    set_id(1, 3, 3, 1, 1, 4, 1, 0, 0); br_taken = 1;
    tick("t4_redirect", 1, RDR, 2'b00, 2'b00, 0, 0);
    br_taken = 0; nop();               tick("t4_after", 1, WE,  2'b00, 2'b00, 0, 1);

    // Test 5: memory wait with a branch latched during the freeze.
    rst_pulse();
    set_id(1, 0, 3, 1, 0, 3, 1, 1, 1); tick("t5_lw",    1, WE,  2'b00, 2'b00, 0, 0);
    nop();                             tick("t5_ex",    1, WE,  2'b00, 2'b00, 0, 0);
    dm_ready = 0; br_taken = 1;        tick("t5_wait1", 1, FRZ, 2'b00, 2'b00, 0, 0);
    br_taken = 0;                      tick("t5_wait2", 1, FRZ, 2'b00, 2'b00, 1, 0);
    tick("t5_wait3", 1, FRZ, 2'b00, 2'b00, 2, 0);
    tick("t5_wait4", 1, FRZ, 2'b00, 2'b00, 3, 0);
    dm_ready = 1;                      tick("t5_flush", 1, RDR, 2'b00, 2'b00, 4, 0);
    tick("t5_after", 1, WE,  2'b00, 2'b00, 4, 1);

    // Test 6: register 0 is never a hazard, then reset mid-wait and mid-stall.
    rst_pulse();
    set_id(1, 1, 0, 1, 0, 0, 1, 1, 1); tick("t6_lw_r0",   1, WE, 2'b00, 2'b00, 0, 0);
    set_id(1, 0, 0, 1, 1, 5, 1, 0, 0); tick("t6_rd_r0",   1, WE, 2'b00, 2'b00, 0, 0);
    nop();                             tick("t6_nofwd0",  1, WE, 2'b00, 2'b00, 0, 0);
    set_id(1, 0, 3, 1, 0, 3, 1, 1, 1); tick("t6_lw3",     1, WE, 2'b00, 2'b00, 0, 0);
    nop();                             tick("t6_ex",      1, WE, 2'b00, 2'b00, 0, 0);
    dm_ready = 0;                      tick("t6_wait1",   1, FRZ, 2'b00, 2'b00, 0, 0);
    br_taken = 1;                      tick("t6_wait2",   1, FRZ, 2'b00, 2'b00, 1, 0);
    br_taken = 0; rst = 0;             tick("t6_rst_wait", 1, WE, 2'b00, 2'b00, 0, 0);
    rst = 1;                           tick("t6_post_wait", 1, WE, 2'b00, 2'b00, 0, 0);
    dm_ready = 1;
    set_id(1, 0, 3, 1, 0, 3, 1, 1, 1); tick("t6_lw3b",    1, WE,  2'b00, 2'b00, 0, 0);
    set_id(1, 3, 3, 1, 1, 4, 1, 0, 0); tick("t6_stall",   1, STL, 2'b00, 2'b00, 0, 0);
    rst = 0;                           tick("t6_rst_stall", 1, WE, 2'b00, 2'b00, 0, 0);
    rst = 1;                           tick("t6_post_stall", 1, WE, 2'b00, 2'b00, 0, 0);

    nop();
    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
